// File: rtl/fp_fma_seq.sv
// fp_fma_seq: sequences FMADD/FMSUB/FNMSUB/FNMADD and single ops over one shared fp_alu
// clk, rst               : rising-edge clock, synchronous active-high reset
// req_valid/req_ready    : request handshake carrying req_op, req_ctrl, rs1, rs2, rs3
// resp_valid/resp_ready  : response handshake carrying resp_data, resp_err
// alu_a/alu_b/alu_ctrl   : operands and control code driven to the shared fp_alu
// alu_result             : combinational result returned by the fp_alu
// busy                   : high whenever the sequencer is not idle
module fp_fma_seq #(
   parameter logic [3:0] IDLE_CTRL = 4'b1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [3:0]  req_ctrl,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] rs3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, EXEC, MUL, ADD, RESP} state_t;
   state_t state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, prod_q, prod_d, data_q, data_d;
   logic [2:0] op_q, op_d;
   logic [3:0] ctrl_q, ctrl_d;
   logic err_q, err_d;
   logic illegal;
   assign illegal = req_op[2] && |req_op[1:0];
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      op_d = op_q;
      ctrl_d = ctrl_q;
      prod_d = prod_q;
      data_d = data_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            a_d = rs1;
            b_d = rs2;
            c_d = rs3;
            op_d = req_op;
            ctrl_d = req_ctrl;
            err_d = illegal;
            data_d = illegal ? 32'h7FC0_0000 : data_q;
            state_d = req_op[2] ? (illegal ? RESP : EXEC) : MUL;
         end
         EXEC: begin
            data_d = alu_result;
            state_d = RESP;
         end
         MUL: begin
            prod_d = alu_result;
            state_d = ADD;
         end
         ADD: begin
            data_d = alu_result;
            state_d = RESP;
         end
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         op_q <= '0;
         ctrl_q <= '0;
         prod_q <= '0;
         data_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         op_q <= op_d;
         ctrl_q <= ctrl_d;
         prod_q <= prod_d;
         data_q <= data_d;
         err_q <= err_d;
      end
   end
   // op[1] negates the product (FNMSUB/FNMADD), op[0] negates the addend (FMSUB/FNMADD)
   assign alu_a = (state_q == EXEC || state_q == MUL) ? a_q :
                  (state_q == ADD) ? {prod_q[31] ^ op_q[1], prod_q[30:0]} : 32'h0;
   assign alu_b = (state_q == EXEC || state_q == MUL) ? b_q :
                  (state_q == ADD) ? {c_q[31] ^ op_q[0], c_q[30:0]} : 32'h0;
   assign alu_ctrl = (state_q == EXEC) ? ctrl_q :
                     (state_q == MUL) ? 4'b0001 :
                     (state_q == ADD) ? 4'b0000 : IDLE_CTRL;
   assign req_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_data = data_q;
   assign resp_err = err_q;
endmodule
